// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encoding and line levels for the FIFO-draining UART transmitter.
// The PARITY state is only reachable when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_parity_calc.sv
// Parity bit generator for the UART frame: even parity when par_typ=0, odd when 1.
// Only built when UART_TX_PARITY_EN is defined.
`ifdef UART_TX_PARITY_EN
module uart_parity_calc #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  always_comb parity = (^data) ^ par_typ;

endmodule
`endif

// File: rtl/fifo_uart_tx.sv
// Drains an async FIFO read port and serialises each word as a UART frame (LSB first).
// Define UART_TX_PARITY_EN to build the optional parity bit; otherwise PAR_EN/PAR_TYP are ignored.
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  REMPTY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  RINC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned CW = $clog2(BIT_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shift;
  logic [BW-1:0]         bit_cnt;
  logic [CW-1:0]         cyc_cnt;
  logic                  bit_done;
  logic                  take;

  always_comb begin
    bit_done = (cyc_cnt == CYC_LAST);
    // REMPTY is only looked at in IDLE and on the last STOP cycle.
    take     = !REMPTY && ((state == IDLE) || ((state == STOP) && bit_done));
  end

`ifdef UART_TX_PARITY_EN
  logic par_bit;
  logic par_en_q;
  logic par_bit_q;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (RDATA),
    .par_typ (PAR_TYP),
    .parity  (par_bit)
  );
`else
  logic unused_par;
  always_comb unused_par = ^{PAR_EN, PAR_TYP};
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      TX_OUT  <= IDLE_LEVEL;
      BUSY    <= 1'b0;
      RINC    <= 1'b0;
      shift   <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      RINC    <= 1'b0;
      cyc_cnt <= bit_done ? '0 : cyc_cnt + 1'b1;
      case (state)
        IDLE: cyc_cnt <= '0;
        START: begin
          if (bit_done) begin
            state   <= DATA;
            TX_OUT  <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state  <= PARITY;
                TX_OUT <= par_bit_q;
              end else begin
                state  <= STOP;
                TX_OUT <= STOP_BIT;
              end
`else
              state  <= STOP;
              TX_OUT <= STOP_BIT;
`endif
            end else begin
              TX_OUT  <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state  <= STOP;
            TX_OUT <= STOP_BIT;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            state  <= IDLE;
            TX_OUT <= IDLE_LEVEL;
            BUSY   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= IDLE_LEVEL;
          BUSY   <= 1'b0;
        end
      endcase

      // Capture overrides the IDLE/STOP updates above, giving back-to-back frames.
      if (take) begin
        state   <= START;
        TX_OUT  <= START_BIT;
        BUSY    <= 1'b1;
        RINC    <= 1'b1;
        shift   <= RDATA;
        cyc_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        par_en_q  <= PAR_EN;
        par_bit_q <= par_bit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a FIFO stand-in, a frame-stream reference model,
// directed frame vectors and randomized traffic on BIT_CYCLES=1 and BIT_CYCLES=4 instances.
module tb_fifo_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rdata;
  logic       rempty;
  logic       par_en;
  logic       par_typ;
  logic       sel;
  logic       rinc1, tx1, busy1;
  logic       rinc4, tx4, busy4;
  logic       tx_s, busy_s, rinc_s;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(8), .BIT_CYCLES(1)) dut (
    .CLK(clk), .RST(rst), .RDATA(rdata), .REMPTY(rempty), .PAR_EN(par_en),
    .PAR_TYP(par_typ), .RINC(rinc1), .TX_OUT(tx1), .BUSY(busy1)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .BIT_CYCLES(4)) dut4 (
    .CLK(clk), .RST(rst), .RDATA(rdata), .REMPTY(rempty), .PAR_EN(par_en),
    .PAR_TYP(par_typ), .RINC(rinc4), .TX_OUT(tx4), .BUSY(busy4)
  );

  always_comb begin
    tx_s   = sel ? tx4   : tx1;
    busy_s = sel ? busy4 : busy1;
    rinc_s = sel ? rinc4 : rinc1;
  end

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    int          nbits;
    logic [10:0] bits;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] fifo_q[$];
  logic       exp_q[$];
  int         rinc_cycles[$];
  int         passed = 0;
  int         total  = 0;
  int         cycle  = 0;
  logic       m_tx, m_busy, m_rinc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
  endtask

  task automatic refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endtask

  task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt);
    int unsigned bc = sel ? 4 : 1;
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PAR_BUILT && pe) bits.push_back(logic'($countones(d) % 2) ^ pt);
    bits.push_back(1'b1);
    foreach (bits[k])
      for (int unsigned r = 0; r < bc; r++) exp_q.push_back(bits[k]);
  endtask

  // One clock: model the line at the edge just passed, compare, then service the FIFO.
  task automatic step();
    @(negedge clk);
    cycle++;
    if (!rst) begin
      exp_q.delete();
      m_tx = 1'b1; m_busy = 1'b0; m_rinc = 1'b0;
    end else begin
      m_rinc = 1'b0;
      if (exp_q.size() == 0 && !rempty) begin
        build_frame(rdata, par_en, par_typ);
        m_rinc = 1'b1;
      end
      if (exp_q.size() != 0) begin
        m_tx = exp_q.pop_front(); m_busy = 1'b1;
      end else begin
        m_tx = 1'b1; m_busy = 1'b0;
      end
    end
    check("model_tx", 32'(tx_s), 32'(m_tx));
    check("model_busy", 32'(busy_s), 32'(m_busy));
    check("model_rinc", 32'(rinc_s), 32'(m_rinc));
    if (rinc_s) begin
      rinc_cycles.push_back(cycle);
      if (fifo_q.size() != 0) fifo_q.delete(0);
    end
    refresh();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      if (!busy_s && rempty && exp_q.size() == 0) return;
      step();
    end
    check("idle_timeout", 32'(busy_s), 32'd0);
  endtask

  initial begin
    int r0;
    int cnt;
`ifdef UART_TX_PARITY_EN
    vecs.push_back('{8'hA5, 1'b0, 1'b0, 10, 11'b01101001010});
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 11, 11'b10101001010});
    vecs.push_back('{8'hA5, 1'b1, 1'b1, 11, 11'b11101001010});
    vecs.push_back('{8'h0F, 1'b1, 1'b0, 11, 11'b10000011110});
`else
    vecs.push_back('{8'hA5, 1'b0, 1'b0, 10, 11'b01101001010});
    vecs.push_back('{8'h0F, 1'b1, 1'b1, 10, 11'b01000011110});
    vecs.push_back('{8'h01, 1'b0, 1'b0, 10, 11'b01000000010});
`endif

    rst = 1'b0; sel = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    fifo_q.push_back(8'h5A);
    refresh();

    // Reset held with a word waiting: line idle, no pop.
    repeat (4) begin
      step();
      check("rst_tx", 32'(tx_s), 32'd1);
      check("rst_busy", 32'(busy_s), 32'd0);
      check("rst_rinc", 32'(rinc_s), 32'd0);
    end
    check("rst_nopop", 32'(fifo_q.size()), 32'd1);
    rst = 1'b1;
    wait_idle();

    // Directed frames; PAR_EN/PAR_TYP flipped mid-frame must not matter.
    foreach (vecs[v]) begin
      wait_idle();
      par_en  = vecs[v].pe;
      par_typ = vecs[v].pt;
      fifo_q.push_back(vecs[v].data);
      refresh();
      r0 = rinc_cycles.size();
      for (int i = 0; i < vecs[v].nbits; i++) begin
        step();
        check($sformatf("vec%0d_bit%0d", v, i), 32'(tx_s), 32'(vecs[v].bits[i]));
        check($sformatf("vec%0d_busy%0d", v, i), 32'(busy_s), 32'd1);
        if (i == 1) begin
          par_en  = ~par_en;
          par_typ = ~par_typ;
        end
      end
      step();
      check($sformatf("vec%0d_idle_tx", v), 32'(tx_s), 32'd1);
      check($sformatf("vec%0d_idle_busy", v), 32'(busy_s), 32'd0);
      check($sformatf("vec%0d_rinc_count", v), 32'(rinc_cycles.size() - r0), 32'd1);
    end

    // Back-to-back 01 then FF.
    wait_idle();
    par_en = 1'b0;
    rinc_cycles.delete();
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'hFF);
    refresh();
    repeat (22) step();
    check("b2b_rinc_count", 32'(rinc_cycles.size()), 32'd2);
    if (rinc_cycles.size() >= 2)
      check("b2b_rinc_spacing", 32'(rinc_cycles[1] - rinc_cycles[0]), 32'd10);

    // Reset while DATA bit 3 is on the line.
    wait_idle();
    fifo_q.push_back(8'hA5);
    refresh();
    repeat (5) step();
    check("mid_d3_tx", 32'(tx_s), 32'd0);
    rst = 1'b0;
    step();
    check("mid_rst_tx", 32'(tx_s), 32'd1);
    check("mid_rst_busy", 32'(busy_s), 32'd0);
    rst = 1'b1;
    r0 = rinc_cycles.size();
    repeat (12) step();
    check("mid_no_rinc", 32'(rinc_cycles.size() - r0), 32'd0);

    // BIT_CYCLES=4 instance: each bit held 4 cycles.
    sel = 1'b1; rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    par_en = 1'b1; par_typ = 1'b1;
    fifo_q.push_back(8'h0F);
    refresh();
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (busy_s) cnt++;
      else if (cnt > 0) break;
    end
    check("bc4_busy_len", 32'(cnt), PAR_BUILT ? 32'd44 : 32'd40);

    // Randomized traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); rst = 1'b0;
      fifo_q.delete();
      refresh();
      repeat (2) step();
      rst = 1'b1;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 5) == 0 && fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
        rst     = ($urandom_range(0, 249) != 0);
        refresh();
        step();
      end
      rst = 1'b1;
      wait_idle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
